// File: rtl/mem_port_arbiter.sv
// Two-requester memory port arbiter: data access over fetch, with a
// bounded run of consecutive data grants, one transaction in flight.
module mem_port_arbiter #(
    parameter int unsigned MAX_DATA_RUN = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic        if_gnt,
    output logic        if_rvalid,
    output logic [31:0] if_rdata,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    input  logic [3:0]  d_wstrb,
    output logic        d_gnt,
    output logic        d_rvalid,
    output logic [31:0] d_rdata,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wstrb,
    input  logic        mem_gnt,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata,
    output logic        arb_busy,
    output logic        arb_owner
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_WAIT
    } state_t;

    localparam logic [3:0] RUN_MAX = 4'(MAX_DATA_RUN);

    state_t      r_state;
    state_t      w_next;
    logic [3:0]  r_run;
    logic        r_we;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [3:0]  r_wstrb;
    logic        r_owner;
    logic        r_if_rvalid;
    logic        r_d_rvalid;
    logic [31:0] r_rdata;
    logic        w_if_win;
    logic        w_d_win;
    logic        w_capture;

    always_comb begin
        w_next    = r_state;
        w_if_win  = 1'b0;
        w_d_win   = 1'b0;
        w_capture = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                // rst_n gating keeps grants quiet while reset is held
                if (rst_n) begin
                    if (d_req && if_req && (r_run == RUN_MAX)) begin
                        w_if_win = 1'b1;
                    end else if (d_req) begin
                        w_d_win = 1'b1;
                    end else if (if_req) begin
                        w_if_win = 1'b1;
                    end
                end
                if (w_if_win || w_d_win) begin
                    w_next = S_REQ;
                end
            end
            S_REQ: begin
                if (mem_gnt && mem_rvalid) begin
                    w_capture = 1'b1;
                    w_next    = S_IDLE;
                end else if (mem_gnt) begin
                    w_next = S_WAIT;
                end
            end
            S_WAIT: begin
                if (mem_rvalid) begin
                    w_capture = 1'b1;
                    w_next    = S_IDLE;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_we    <= 1'b0;
            r_addr  <= 32'd0;
            r_wdata <= 32'd0;
            r_wstrb <= 4'd0;
            r_owner <= 1'b0;
        end else if (w_d_win) begin
            r_we    <= d_we;
            r_addr  <= d_addr;
            r_wdata <= d_wdata;
            r_wstrb <= d_we ? d_wstrb : 4'd0;
            r_owner <= 1'b1;
        end else if (w_if_win) begin
            r_we    <= 1'b0;
            r_addr  <= if_addr;
            r_wdata <= 32'd0;
            r_wstrb <= 4'd0;
            r_owner <= 1'b0;
        end
    end

    // Run only counts data grants that made a waiting fetch wait longer
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_run <= 4'd0;
        end else if (w_if_win) begin
            r_run <= 4'd0;
        end else if (w_d_win) begin
            if (!if_req) begin
                r_run <= 4'd0;
            end else if (r_run != RUN_MAX) begin
                r_run <= r_run + 4'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_if_rvalid <= 1'b0;
            r_d_rvalid  <= 1'b0;
            r_rdata     <= 32'd0;
        end else begin
            r_if_rvalid <= w_capture && !r_owner;
            r_d_rvalid  <= w_capture && r_owner;
            if (w_capture) begin
                r_rdata <= mem_rdata;
            end
        end
    end

    assign if_gnt    = w_if_win;
    assign d_gnt     = w_d_win;
    assign if_rvalid = r_if_rvalid;
    assign d_rvalid  = r_d_rvalid;
    assign if_rdata  = r_rdata;
    assign d_rdata   = r_rdata;
    assign mem_req   = (r_state == S_REQ);
    assign mem_we    = r_we;
    assign mem_addr  = r_addr;
    assign mem_wdata = r_wdata;
    assign mem_wstrb = r_wstrb;
    assign arb_busy  = (r_state != S_IDLE);
    assign arb_owner = r_owner;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: per-cycle vector table plus
// hand sequences for starvation, stall, reset and stray responses.
module tb_mem_port_arbiter;

    logic        clk;
    logic        rst_n;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_gnt;
    logic        if_rvalid;
    logic [31:0] if_rdata;
    logic        d_req;
    logic        d_we;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic [3:0]  d_wstrb;
    logic        d_gnt;
    logic        d_rvalid;
    logic [31:0] d_rdata;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        mem_gnt;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;
    logic        arb_busy;
    logic        arb_owner;

    int n_cmp = 0;
    int n_err = 0;

    mem_port_arbiter #(.MAX_DATA_RUN(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
        .if_rvalid(if_rvalid), .if_rdata(if_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr),
        .d_wdata(d_wdata), .d_wstrb(d_wstrb), .d_gnt(d_gnt),
        .d_rvalid(d_rvalid), .d_rdata(d_rdata),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
        .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid),
        .mem_rdata(mem_rdata),
        .arb_busy(arb_busy), .arb_owner(arb_owner)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        ir;
        logic [31:0] ia;
        logic        dr;
        logic        dwe;
        logic [31:0] da;
        logic [31:0] dwd;
        logic [3:0]  dws;
        logic        mg;
        logic        mv;
        logic [31:0] md;
        logic        e_ig;
        logic        e_dg;
        logic        e_irv;
        logic        e_drv;
        logic        e_mreq;
        logic        e_mwe;
        logic [31:0] e_ma;
        logic [3:0]  e_mws;
        logic        e_busy;
        logic        e_own;
        logic [31:0] e_rd;
    } vec_t;

    function automatic vec_t mk(
        input logic ir, input logic [31:0] ia,
        input logic dr, input logic dwe, input logic [31:0] da,
        input logic [31:0] dwd, input logic [3:0] dws,
        input logic mg, input logic mv, input logic [31:0] md,
        input logic e_ig, input logic e_dg,
        input logic e_irv, input logic e_drv,
        input logic e_mreq, input logic e_mwe,
        input logic [31:0] e_ma, input logic [3:0] e_mws,
        input logic e_busy, input logic e_own,
        input logic [31:0] e_rd);
        vec_t v;
        v.ir = ir; v.ia = ia; v.dr = dr; v.dwe = dwe; v.da = da;
        v.dwd = dwd; v.dws = dws; v.mg = mg; v.mv = mv; v.md = md;
        v.e_ig = e_ig; v.e_dg = e_dg; v.e_irv = e_irv;
        v.e_drv = e_drv; v.e_mreq = e_mreq; v.e_mwe = e_mwe;
        v.e_ma = e_ma; v.e_mws = e_mws; v.e_busy = e_busy;
        v.e_own = e_own; v.e_rd = e_rd;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic quiet();
        if_req = 0; if_addr = 0; d_req = 0; d_we = 0;
        d_addr = 0; d_wdata = 0; d_wstrb = 0;
        mem_gnt = 0; mem_rvalid = 0; mem_rdata = 0;
    endtask

    vec_t tbl[13];
    logic exp_ord[10] = '{1, 1, 1, 1, 0, 1, 1, 1, 1, 0};
    logic [31:0] snap_i;
    logic [31:0] snap_d;
    int k;

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

    initial begin
        // cycles: IF read (1), D store vs IF (2), D load wstrb masking
        tbl[0]  = mk(1,'h100,0,0,0,0,0, 0,0,0,
                     1,0,0,0,0,0,'h0,0,0,0,0);
        tbl[1]  = mk(0,0,0,0,0,0,0, 1,0,0,
                     0,0,0,0,1,0,'h100,0,1,0,0);
        tbl[2]  = mk(0,0,0,0,0,0,0, 0,0,0,
                     0,0,0,0,0,0,'h100,0,1,0,0);
        tbl[3]  = mk(0,0,0,0,0,0,0, 0,1,'hDEADBEEF,
                     0,0,0,0,0,0,'h100,0,1,0,0);
        tbl[4]  = mk(0,0,0,0,0,0,0, 0,0,0,
                     0,0,1,0,0,0,'h100,0,0,0,'hDEADBEEF);
        tbl[5]  = mk(1,'h200,1,1,'h2000,'h55AA55AA,4'b0011, 0,0,0,
                     0,1,0,0,0,0,'h100,0,0,0,0);
        tbl[6]  = mk(1,'h200,0,0,0,0,0, 1,1,'h0BADF00D,
                     0,0,0,0,1,1,'h2000,4'b0011,1,1,0);
        tbl[7]  = mk(1,'h200,0,0,0,0,0, 0,0,0,
                     1,0,0,1,0,1,'h2000,4'b0011,0,1,'h0BADF00D);
        tbl[8]  = mk(0,0,0,0,0,0,0, 1,1,'hCAFEF00D,
                     0,0,0,0,1,0,'h200,0,1,0,0);
        tbl[9]  = mk(0,0,0,0,0,0,0, 0,0,0,
                     0,0,1,0,0,0,'h200,0,0,0,'hCAFEF00D);
        tbl[10] = mk(0,0,1,0,'h3000,'h99,4'hF, 0,0,0,
                     0,1,0,0,0,0,'h200,0,0,0,0);
        tbl[11] = mk(0,0,0,0,0,0,0, 1,1,'h11112222,
                     0,0,0,0,1,0,'h3000,0,1,1,0);
        tbl[12] = mk(0,0,0,0,0,0,0, 0,0,0,
                     0,0,0,1,0,0,'h3000,0,0,1,'h11112222);

        // reset with a fetch request present: everything stays zero
        quiet();
        rst_n = 0;
        if_req = 1; if_addr = 'h40;
        @(negedge clk); @(negedge clk); #1;
        chk("rst if_gnt", if_gnt, 0);
        chk("rst d_gnt", d_gnt, 0);
        chk("rst mem_req", mem_req, 0);
        chk("rst mem_addr", mem_addr, 0);
        chk("rst mem_wstrb", mem_wstrb, 0);
        chk("rst busy", arb_busy, 0);
        chk("rst owner", arb_owner, 0);
        chk("rst rvalid", {if_rvalid, d_rvalid}, 0);
        if_req = 0; if_addr = 0;
        @(negedge clk);
        rst_n = 1;

        for (int i = 0; i < 13; i++) begin
            @(negedge clk);
            if_req = tbl[i].ir; if_addr = tbl[i].ia;
            d_req = tbl[i].dr; d_we = tbl[i].dwe;
            d_addr = tbl[i].da; d_wdata = tbl[i].dwd;
            d_wstrb = tbl[i].dws;
            mem_gnt = tbl[i].mg; mem_rvalid = tbl[i].mv;
            mem_rdata = tbl[i].md;
            #1;
            chk($sformatf("v%0d if_gnt", i), if_gnt, tbl[i].e_ig);
            chk($sformatf("v%0d d_gnt", i), d_gnt, tbl[i].e_dg);
            chk($sformatf("v%0d if_rv", i), if_rvalid, tbl[i].e_irv);
            chk($sformatf("v%0d d_rv", i), d_rvalid, tbl[i].e_drv);
            chk($sformatf("v%0d mreq", i), mem_req, tbl[i].e_mreq);
            chk($sformatf("v%0d mwe", i), mem_we, tbl[i].e_mwe);
            chk($sformatf("v%0d maddr", i), mem_addr, tbl[i].e_ma);
            chk($sformatf("v%0d mwstrb", i), mem_wstrb, tbl[i].e_mws);
            chk($sformatf("v%0d busy", i), arb_busy, tbl[i].e_busy);
            chk($sformatf("v%0d owner", i), arb_owner, tbl[i].e_own);
            if (tbl[i].e_irv)
                chk($sformatf("v%0d if_rd", i), if_rdata, tbl[i].e_rd);
            if (tbl[i].e_drv)
                chk($sformatf("v%0d d_rd", i), d_rdata, tbl[i].e_rd);
        end

        // starvation limit with both requesters always asking
        @(negedge clk);
        quiet();
        mem_gnt = 1; mem_rvalid = 1; mem_rdata = 'h5;
        if_req = 1; if_addr = 'h400;
        d_req = 1; d_addr = 'h5000;
        k = 0;
        for (int cyc = 0; cyc < 60 && k < 10; cyc++) begin
            #1;
            if (if_gnt || d_gnt) begin
                chk($sformatf("order%0d", k), d_gnt, exp_ord[k]);
                k++;
            end
            @(negedge clk);
        end
        chk("grants seen", k, 10);
        if_req = 0; d_req = 0;
        @(negedge clk);
        mem_gnt = 0; mem_rvalid = 0;

        // memory stalls mem_gnt for 5 cycles
        @(negedge clk);
        d_req = 1; d_we = 1; d_addr = 'h4000;
        d_wdata = 'hA5A50F0F; d_wstrb = 4'hC;
        if_req = 1; if_addr = 'h500;
        #1;
        chk("st d_gnt", d_gnt, 1);
        chk("st if_gnt", if_gnt, 0);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            d_req = 0; d_addr = 0; d_wdata = 0; d_wstrb = 0;
            #1;
            chk($sformatf("st%0d mreq", c), mem_req, 1);
            chk($sformatf("st%0d maddr", c), mem_addr, 'h4000);
            chk($sformatf("st%0d wdata", c), mem_wdata, 'hA5A50F0F);
            chk($sformatf("st%0d wstrb", c), mem_wstrb, 4'hC);
            chk($sformatf("st%0d we", c), mem_we, 1);
            chk($sformatf("st%0d busy", c), arb_busy, 1);
            chk($sformatf("st%0d gnt", c), {if_gnt, d_gnt}, 0);
        end
        @(negedge clk);
        mem_gnt = 1; mem_rvalid = 1; mem_rdata = 'h77;
        @(negedge clk);
        #1;
        chk("st d_rv", d_rvalid, 1);
        chk("st d_rd", d_rdata, 'h77);
        chk("st if_gnt2", if_gnt, 1);
        @(negedge clk);
        if_req = 0;
        @(negedge clk);
        #1;
        chk("st if_rv", if_rvalid, 1);
        mem_gnt = 0; mem_rvalid = 0;

        // reset while D transaction is waiting for its response
        @(negedge clk);
        d_req = 1; d_we = 0; d_addr = 'h6000;
        #1;
        chk("rw d_gnt", d_gnt, 1);
        @(negedge clk);
        d_req = 0; mem_gnt = 1;
        @(negedge clk);
        mem_gnt = 0;
        #1;
        chk("rw wait busy", arb_busy, 1);
        rst_n = 0;
        #1;
        chk("rw mreq", mem_req, 0);
        chk("rw busy", arb_busy, 0);
        @(negedge clk);
        rst_n = 1; mem_rvalid = 1; mem_rdata = 'hDEAD0001;
        #1;
        chk("rw d_rv0", d_rvalid, 0);
        @(negedge clk);
        mem_rvalid = 0;
        #1;
        chk("rw d_rv1", d_rvalid, 0);
        chk("rw if_rv1", if_rvalid, 0);
        @(negedge clk);
        if_req = 1; if_addr = 'h700;
        #1;
        chk("rw if_gnt", if_gnt, 1);
        @(negedge clk);
        if_req = 0; mem_gnt = 1; mem_rvalid = 1; mem_rdata = 'h600DCAFE;
        #1;
        chk("rw maddr", mem_addr, 'h700);
        chk("rw mreq2", mem_req, 1);
        @(negedge clk);
        mem_gnt = 0; mem_rvalid = 0;
        #1;
        chk("rw if_rv", if_rvalid, 1);
        chk("rw if_rd", if_rdata, 'h600DCAFE);
        chk("rw d_rv2", d_rvalid, 0);

        // stray response while idle is ignored
        @(negedge clk);
        snap_i = if_rdata; snap_d = d_rdata;
        mem_rvalid = 1; mem_rdata = 'h12345678;
        #1;
        chk("idle rv0", {if_rvalid, d_rvalid}, 0);
        @(negedge clk);
        mem_rvalid = 0;
        #1;
        chk("idle rv1", {if_rvalid, d_rvalid}, 0);
        chk("idle if_rd", if_rdata, snap_i);
        chk("idle d_rd", d_rdata, snap_d);
        chk("idle busy", arb_busy, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single memory port between two requesters: instruction fetch (IF) and the MEM-stage data access (D, driven from the exe/mem bus mem_we/mem_re path).
- Only one transaction is outstanding at a time.
- Arbitration is fixed-priority, D over IF, with an anti-starvation limit on consecutive D grants.
- Responses are routed back to the owning requester with a one-cycle registered return.

Parameters:
- MAX_DATA_RUN, 4: maximum number of consecutive D grants while if_req is pending; the next arbitration after that goes to IF. Legal range is 1..15.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- if_req  in  1  fetch request; held high until if_gnt
- if_addr  in  32  fetch address
- if_gnt  out  1  one-cycle pulse; fetch request accepted
- if_rvalid  out  1  one-cycle pulse; fetch data valid
- if_rdata  out  32  fetch data
- d_req  in  1  data request; held high until d_gnt
- d_we  in  1  1 = store, 0 = load
- d_addr  in  32  data address
- d_wdata  in  32  store data
- d_wstrb  in  4  store byte enables
- d_gnt  out  1  one-cycle pulse; data request accepted
- d_rvalid  out  1  one-cycle pulse; load data or store completion
- d_rdata  out  32  load data (mem_rdata is passed through for stores too)
- mem_req  out  1  request to memory; held until mem_gnt
- mem_we  out  1  write enable
- mem_addr  out  32  address
- mem_wdata  out  32  write data
- mem_wstrb  out  4  byte enables; 4'b0000 for reads
- mem_gnt  in  1  memory accepted the request
- mem_rvalid  in  1  memory response valid
- mem_rdata  in  32  memory read data
- arb_busy  out  1  high in REQ or WAIT
- arb_owner  out  1  owner of the current or last transaction (0 = IF, 1 = D)

Behaviour:
Reset:
- State is IDLE.
- All outputs are 0: gnt, rvalid, mem_req, mem_we, mem_wstrb, addr/data, arb_owner.
- run counter is 0.
- Reset asserted mid-transaction drops mem_req immediately.
- Any pending response is discarded; no rvalid is generated for it.

FSM states: IDLE, REQ, WAIT. All transitions occur on the rising edge of clk.

IDLE:
- Arbitration each cycle:
  - If d_req and if_req are both high and run == MAX_DATA_RUN: IF wins.
  - Otherwise, if d_req: D wins.
  - Otherwise, if if_req: IF wins.
- On a win, the winner's gnt pulses combinationally in that same cycle.
- At the edge, the winner's fields are latched into the mem_* registers and arb_owner; the next state is REQ.
- For an IF win: mem_we = 0, mem_wstrb = 0, mem_wdata = 0.
- For a D load: mem_wstrb is forced to 0.

run counter (saturating at MAX_DATA_RUN):
- Increments on a D grant while if_req is high.
- Clears on an IF grant.
- Clears on a D grant while if_req is low.

REQ:
- mem_req = 1, with all mem_* fields stable.
- If mem_gnt && mem_rvalid: next state is IDLE; the response is captured.
- Else if mem_gnt: next state is WAIT.
- Otherwise stay in REQ. There is no timeout.

WAIT:
- mem_req = 0.
- On mem_rvalid: capture mem_rdata; next state is IDLE.

Response path:
- Registered. The cycle after capture, the owner's rvalid = 1 for exactly one cycle and rdata = the captured data.
- The non-owner's rvalid stays 0. rdata holds its value until the next capture.

Timing:
- The IDLE state coincident with the rvalid cycle may arbitrate and grant a new request, giving back-to-back transactions.
- Minimum request-to-rvalid latency is 3 cycles (gnt cycle, REQ with mem_gnt+mem_rvalid, rvalid cycle).

Ignored inputs and requester rules:
- mem_rvalid is ignored in IDLE.
- mem_gnt is ignored outside REQ.
- Requester rule: req may drop only after its gnt. A req that drops before gnt is simply not arbitrated.

Test Plan:
1. Reset, then if_req with if_addr=0x100; memory gives mem_gnt in cycle 1 and mem_rvalid 2 cycles later with 0xDEADBEEF -> if_gnt pulses once; mem_addr=0x100, mem_we=0, mem_wstrb=0; if_rvalid=1 for one cycle with if_rdata=0xDEADBEEF; d_rvalid stays 0.
2. if_req and d_req rise together, with d store addr 0x2000, wdata 0x55AA55AA, wstrb 4'b0011 -> d_gnt first; mem_we=1, mem_wstrb=4'b0011; if_gnt follows in the IDLE cycle after d_rvalid.
3. Continuous d_req and if_req with MAX_DATA_RUN=4 and a zero-wait memory -> grant order D,D,D,D,IF,D,D,D,D,IF; run counter clears after each IF grant.
4. Memory holds mem_gnt low for 5 cycles in REQ -> mem_req and all mem_* fields are stable for all 5 cycles; no new gnt is issued; arb_busy=1 throughout.
5. Assert rst_n=0 while in WAIT with D as owner, then deassert and drive mem_rvalid -> mem_req=0 and arb_busy=0 immediately; no d_rvalid is produced; the next if_req is served normally.
6. mem_rvalid pulse with rdata 0x12345678 while in IDLE and no request -> no rvalid on either port; if_rdata and d_rdata are unchanged.
